interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Sits directly downstream of the interrupt timer in the interrupt_handler subsystem.
- Collects the timer's int_fire pulse plus the other peripheral interrupt lines.
- Latches each rising edge as a pending request, applies a per-source mask and a global enable, and picks the highest-priority eligible source.
- Presents that source to the CPU through a req/ack/done handshake, one interrupt in service at a time.

Parameters:
NUM_SRC, 8, number of interrupt sources; bit 0 is wired to timer int_fire and has the highest priority.
ID_W, 3, width of int_id; must equal clog2(NUM_SRC).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
nrst  input  1  asynchronous active-low reset.
src_irq  input  NUM_SRC  raw interrupt lines; pulses or levels, rising edge is the event.
irq_mask  input  NUM_SRC  per-source enable; 1 = source may be serviced.
global_en  input  1  master interrupt enable.
int_ack  input  1  CPU accepts the presented interrupt; 1-cycle pulse.
int_done  input  1  CPU handler finished (return from interrupt); 1-cycle pulse.
int_req  output  1  registered interrupt request to the CPU.
int_id  output  ID_W  registered index of the requested or in-service source.
pending  output  NUM_SRC  registered pending bits, readable by software.
busy  output  1  high while an interrupt is in service.

Behaviour:
Reset (nrst low, asynchronous):
- int_req=0, int_id=0, pending=0, busy=0.
- Edge-detect history prev=0; FSM in IDLE.

Edge detect:
- event[i] = src_irq[i] & ~prev[i]; prev <= src_irq every cycle.
- A source already high on the first clock after reset release counts as one event.
- A held-high level produces only one event.

Pending register:
- pending[i] is set by event[i], regardless of irq_mask and global_en.
- pending[int_id] is cleared when int_ack is accepted in REQ.
- Set and clear on the same bit in the same cycle: set wins; the new event is retained.
- Repeated events on an already-pending bit merge into one; there is no counting.

Eligibility and priority:
- eligible = pending & irq_mask, gated by global_en.
- Priority is fixed: the lowest index wins.

FSM states:
- IDLE: if eligible is nonzero, go to REQ, load int_id with the winning index, set int_req=1.
- REQ:
  - int_id is held stable; there is no preemption by higher-priority arrivals.
  - On int_ack: clear pending[int_id], go to SERVICE, int_req=0, busy=1.
  - Otherwise, if pending[int_id] & irq_mask[int_id] & global_en is 0 (withdrawn), go to IDLE with int_req=0.
- SERVICE:
  - busy=1 and int_id is held.
  - New events keep accumulating in pending.
  - On int_done: go to IDLE with busy=0.

Handshake rules:
- int_ack outside REQ is ignored; int_done outside SERVICE is ignored.
- int_ack and int_done in the same cycle in REQ: only the ack is taken.

Latency:
- An event sampled at clock edge k gives pending[i]=1 after edge k.
- With the FSM in IDLE, int_req=1 after edge k+1.
- After int_done at edge d, the next request can assert no earlier than after edge d+1 (one IDLE cycle minimum).

Reset mid-operation: all state returns to reset values immediately and in-flight requests are lost.

Test Plan:
- Reset, mask=8'hFF, global_en=1, pulse src_irq[0] for 1 cycle at edge k -> pending=8'h01 after k; int_req=1, int_id=0 after k+1; ack -> pending=0, busy=1, int_req=0; done -> busy=0, IDLE.
- Events on src 5 and src 2 in the same cycle -> int_id=2 first. After ack and done, int_id=5 is presented 2 edges after done (one IDLE cycle, then REQ).
- irq_mask=8'hFE, pulse src 0 -> pending[0]=1 and int_req stays 0. Set mask[0]=1 -> int_req=1 with int_id=0 one edge later.
- In REQ with int_id=3, drop global_en before ack -> int_req=0 next edge and pending[3] stays 1. Re-enable -> request re-asserts with int_id=3.
- In SERVICE on src 1, new event on src 1 plus an event on src 0 -> pending=8'h03, no int_req until int_done. Then int_id=0 is presented, followed by 1.
- Hold src_irq[4] high for 10 cycles -> exactly one pending set. Event arriving in the same cycle as the ack for the same id -> pending stays 1.
- Assert nrst low while busy=1 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake bundle: request/id/busy out of the controller,
// ack/done back from the CPU.
interface interrupt_controller_if #(
  parameter int ID_W = 3
);
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            busy;
  logic            int_ack;
  logic            int_done;

  modport master (output int_req, output int_id, output busy,
                  input  int_ack, input  int_done);
  modport slave  (input  int_req, input  int_id, input  busy,
                  output int_ack, output int_done);
endinterface

// File: rtl/interrupt_controller.sv
// Edge-latched pending interrupts, fixed priority (bit 0 highest), one in
// service at a time via req/ack/done.
//
// state   | meaning
// IDLE    | nothing presented; waiting for an eligible pending source
// REQ     | int_req high, int_id frozen, waiting for ack or withdrawal
// SERVICE | CPU handler running (busy), waiting for done
module interrupt_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NUM_SRC-1:0]     src_irq,
  input  logic [NUM_SRC-1:0]     irq_mask,
  input  logic                   global_en,
  output logic [NUM_SRC-1:0]     pending,
  interrupt_controller_if.master cpu
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   prev_q, prev_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]      int_id_q, int_id_d;
  logic                 int_req_q, int_req_d;
  logic                 busy_q, busy_d;

  logic [NUM_SRC-1:0]   edge_evt;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [ID_W-1:0]      win_id;
  logic                 cur_ok;

  assign edge_evt = src_irq & ~prev_q;
  assign eligible = global_en ? (pending_q & irq_mask) : '0;
  assign cur_ok   = pending_q[int_id_q] & irq_mask[int_id_q] & global_en;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    int_id_d  = int_id_q;
    int_req_d = int_req_q;
    busy_d    = busy_q;
    ack_clr   = '0;
    prev_d    = src_irq;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d   = REQ;
          int_id_d  = win_id;
          int_req_d = 1'b1;
        end
      end
      REQ: begin
        if (cpu.int_ack) begin
          ack_clr[int_id_q] = 1'b1;
          state_d   = SERVICE;
          int_req_d = 1'b0;
          busy_d    = 1'b1;
        end else if (!cur_ok) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        if (cpu.int_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    // A fresh edge on the bit being acknowledged survives the clear.
    pending_d = (pending_q & ~ack_clr) | edge_evt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      int_id_q  <= '0;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      int_id_q  <= int_id_d;
      int_req_q <= int_req_d;
      busy_q    <= busy_d;
    end
  end

  assign pending     = pending_q;
  assign cpu.int_req = int_req_q;
  assign cpu.int_id  = int_id_q;
  assign cpu.busy    = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: each task drives one scenario and
// compares against hand-derived values one time unit after the rising edge.
module tb_interrupt_controller;

  logic       clk;
  logic       nrst;
  logic [7:0] src_irq;
  logic [7:0] irq_mask;
  logic       global_en;
  logic [7:0] pending;
  int         checks;
  int         failures;

  interrupt_controller_if #(.ID_W(3)) cpu_if ();

  interrupt_controller #(.NUM_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .src_irq   (src_irq),
    .irq_mask  (irq_mask),
    .global_en (global_en),
    .pending   (pending),
    .cpu       (cpu_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    cpu_if.int_ack = 1'b1;
    step();
    cpu_if.int_ack = 1'b0;
  endtask

  task automatic do_done();
    cpu_if.int_done = 1'b1;
    step();
    cpu_if.int_done = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; src_irq = '0; irq_mask = '0; global_en = 1'b0;
    cpu_if.int_ack = 1'b0; cpu_if.int_done = 1'b0;
    #3;
    checks++; if (cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", cpu_if.int_req); end
    checks++; if (cpu_if.int_id !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", cpu_if.int_id); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (cpu_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", cpu_if.busy); end
    step();
    nrst = 1'b1; irq_mask = 8'hFF; global_en = 1'b1;
    step();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_idle_pending got=%h exp=00", pending); end
  endtask

  task automatic test_single();
    src_irq = 8'h01;
    step();
    src_irq = 8'h00;
    checks++; if (pending !== 8'h01) begin failures++; $display("FAIL single_pending got=%h exp=01", pending); end
    checks++; if (cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL single_req_early got=%0b exp=0", cpu_if.int_req); end
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd0) begin failures++; $display("FAIL single_req got=%0b/%0d exp=1/0", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    checks++; if (pending !== 8'h00 || cpu_if.busy !== 1'b1 || cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL single_ack got=%h/%0b/%0b exp=00/1/0", pending, cpu_if.busy, cpu_if.int_req); end
    do_done();
    checks++; if (cpu_if.busy !== 1'b0 || cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL single_done got=%0b/%0b exp=0/0", cpu_if.busy, cpu_if.int_req); end
    step();
    checks++; if (cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", cpu_if.int_req); end
  endtask

  task automatic test_priority();
    src_irq = 8'h24;
    step();
    src_irq = 8'h00;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd2 || pending !== 8'h24) begin failures++; $display("FAIL prio_first got=%0b/%0d/%h exp=1/2/24", cpu_if.int_req, cpu_if.int_id, pending); end
    do_ack();
    checks++; if (pending !== 8'h20 || cpu_if.busy !== 1'b1) begin failures++; $display("FAIL prio_ack got=%h/%0b exp=20/1", pending, cpu_if.busy); end
    do_done();
    checks++; if (cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL prio_idle_gap got=%0b exp=0", cpu_if.int_req); end
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd5) begin failures++; $display("FAIL prio_second got=%0b/%0d exp=1/5", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    do_done();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL prio_drain got=%h exp=00", pending); end
  endtask

  task automatic test_mask();
    irq_mask = 8'hFE;
    src_irq = 8'h01;
    step();
    src_irq = 8'h00;
    step();
    step();
    checks++; if (pending !== 8'h01 || cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL mask_hold got=%h/%0b exp=01/0", pending, cpu_if.int_req); end
    irq_mask = 8'hFF;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd0) begin failures++; $display("FAIL mask_release got=%0b/%0d exp=1/0", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    do_done();
  endtask

  task automatic test_withdraw();
    src_irq = 8'h08;
    step();
    src_irq = 8'h00;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd3) begin failures++; $display("FAIL wd_req got=%0b/%0d exp=1/3", cpu_if.int_req, cpu_if.int_id); end
    global_en = 1'b0;
    step();
    checks++; if (cpu_if.int_req !== 1'b0 || pending !== 8'h08) begin failures++; $display("FAIL wd_drop got=%0b/%h exp=0/08", cpu_if.int_req, pending); end
    step();
    checks++; if (cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL wd_stay got=%0b exp=0", cpu_if.int_req); end
    global_en = 1'b1;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd3) begin failures++; $display("FAIL wd_reassert got=%0b/%0d exp=1/3", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    do_done();
  endtask

  task automatic test_service_accum();
    src_irq = 8'h02;
    step();
    src_irq = 8'h00;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd1) begin failures++; $display("FAIL acc_req got=%0b/%0d exp=1/1", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    src_irq = 8'h03;
    step();
    src_irq = 8'h00;
    checks++; if (pending !== 8'h03 || cpu_if.int_req !== 1'b0 || cpu_if.busy !== 1'b1) begin failures++; $display("FAIL acc_pending got=%h/%0b/%0b exp=03/0/1", pending, cpu_if.int_req, cpu_if.busy); end
    step();
    checks++; if (cpu_if.int_req !== 1'b0 || cpu_if.int_id !== 3'd1) begin failures++; $display("FAIL acc_hold got=%0b/%0d exp=0/1", cpu_if.int_req, cpu_if.int_id); end
    do_done();
    checks++; if (cpu_if.busy !== 1'b0 || cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL acc_done got=%0b/%0b exp=0/0", cpu_if.busy, cpu_if.int_req); end
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd0) begin failures++; $display("FAIL acc_next0 got=%0b/%0d exp=1/0", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    checks++; if (pending !== 8'h02) begin failures++; $display("FAIL acc_ack0 got=%h exp=02", pending); end
    do_done();
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd1) begin failures++; $display("FAIL acc_next1 got=%0b/%0d exp=1/1", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    do_done();
  endtask

  task automatic test_level_and_collision();
    int extra_sets;
    extra_sets = 0;
    src_irq = 8'h10;
    step();
    checks++; if (pending !== 8'h10) begin failures++; $display("FAIL lvl_first got=%h exp=10", pending); end
    step();
    do_ack();
    for (int i = 0; i < 7; i++) begin
      step();
      if (pending !== 8'h00) extra_sets++;
    end
    src_irq = 8'h00;
    checks++; if (extra_sets !== 0) begin failures++; $display("FAIL lvl_single got=%0d exp=0", extra_sets); end
    do_done();
    step();
    checks++; if (cpu_if.int_req !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL lvl_idle got=%0b/%h exp=0/00", cpu_if.int_req, pending); end
    src_irq = 8'h40;
    step();
    src_irq = 8'h00;
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd6) begin failures++; $display("FAIL col_req got=%0b/%0d exp=1/6", cpu_if.int_req, cpu_if.int_id); end
    src_irq = 8'h40;
    do_ack();
    src_irq = 8'h00;
    checks++; if (pending !== 8'h40 || cpu_if.busy !== 1'b1) begin failures++; $display("FAIL col_setwins got=%h/%0b exp=40/1", pending, cpu_if.busy); end
    do_done();
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd6) begin failures++; $display("FAIL col_again got=%0b/%0d exp=1/6", cpu_if.int_req, cpu_if.int_id); end
    do_ack();
    do_done();
  endtask

  task automatic test_ignored_handshake();
    do_ack();
    checks++; if (cpu_if.busy !== 1'b0 || cpu_if.int_req !== 1'b0) begin failures++; $display("FAIL ign_ack_idle got=%0b/%0b exp=0/0", cpu_if.busy, cpu_if.int_req); end
    src_irq = 8'h80;
    step();
    src_irq = 8'h00;
    step();
    do_done();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd7 || cpu_if.busy !== 1'b0) begin failures++; $display("FAIL ign_done_req got=%0b/%0d/%0b exp=1/7/0", cpu_if.int_req, cpu_if.int_id, cpu_if.busy); end
    cpu_if.int_ack = 1'b1; cpu_if.int_done = 1'b1;
    step();
    cpu_if.int_ack = 1'b0; cpu_if.int_done = 1'b0;
    checks++; if (cpu_if.busy !== 1'b1 || pending !== 8'h00) begin failures++; $display("FAIL ign_ack_done got=%0b/%h exp=1/00", cpu_if.busy, pending); end
    do_done();
  endtask

  task automatic test_reset_mid();
    src_irq = 8'h01;
    step();
    src_irq = 8'h00;
    step();
    do_ack();
    src_irq = 8'h06;
    step();
    checks++; if (cpu_if.busy !== 1'b1 || pending !== 8'h06) begin failures++; $display("FAIL rst_pre got=%0b/%h exp=1/06", cpu_if.busy, pending); end
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (cpu_if.busy !== 1'b0 || cpu_if.int_req !== 1'b0 || cpu_if.int_id !== 3'd0 || pending !== 8'h00) begin failures++; $display("FAIL rst_async got=%0b/%0b/%0d/%h exp=0/0/0/00", cpu_if.busy, cpu_if.int_req, cpu_if.int_id, pending); end
    src_irq = 8'h04;
    step();
    nrst = 1'b1;
    step();
    checks++; if (pending !== 8'h04) begin failures++; $display("FAIL rst_first_level got=%h exp=04", pending); end
    step();
    checks++; if (cpu_if.int_req !== 1'b1 || cpu_if.int_id !== 3'd2) begin failures++; $display("FAIL rst_first_req got=%0b/%0d exp=1/2", cpu_if.int_req, cpu_if.int_id); end
    src_irq = 8'h00;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_withdraw();
    test_service_accum();
    test_level_and_collision();
    test_ignored_handshake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
